// File: rtl/ddr3_rd_stream.sv
// ddr3_rd_stream: streams a block of DDR3 read beats out to a valid/ready consumer.
//
// On a rising edge of rd_start the block latches rd_base_addr/rd_total and reads rd_total
// beats in chunks of at most MAX_BURST. A read command is only issued once the output FIFO
// has room for the whole chunk, because DDR read data cannot be stalled. Only one command
// is ever outstanding, so beats reach the consumer in issue order.
//
// Ports:
//   ui_clk, ui_rst_n         clock, synchronous active-low reset
//   rd_start                 start trigger (rising edge), ignored while rd_busy
//   rd_base_addr, rd_total   transfer start address and length in beats
//   ddr_rdy                  controller can accept a command
//   ddr_rd_data(_valid)      read beats from the controller, no backpressure
//   ddr_rd_finish            pulse: current read command complete
//   ddr_cmd(_valid)          command strobe (1=READ, 2=IDLE)
//   ddr_base_addr, ddr_size  chunk start address and length
//   m_data/m_valid/m_ready   output stream
//   rd_busy, rd_done         transfer in progress / complete and drained
//   len_err, proto_err       sticky error flags, cleared on the next accepted start
module ddr3_rd_stream #(
  parameter int DDR_WIDTH  = 64,
  parameter int UI_WIDTH   = DDR_WIDTH * 8,
  parameter int ADDR_WIDTH = 29,
  parameter int ADDR_STEP  = 8,
  parameter int FIFO_DEPTH = 256,
  parameter int MAX_BURST  = 128
) (
  input  logic                  ui_clk,
  input  logic                  ui_rst_n,
  input  logic                  rd_start,
  input  logic [ADDR_WIDTH-1:0] rd_base_addr,
  input  logic [15:0]           rd_total,
  input  logic                  ddr_rdy,
  input  logic [UI_WIDTH-1:0]   ddr_rd_data,
  input  logic                  ddr_rd_data_valid,
  input  logic                  ddr_rd_finish,
  output logic [2:0]            ddr_cmd,
  output logic                  ddr_cmd_valid,
  output logic [ADDR_WIDTH-1:0] ddr_base_addr,
  output logic [9:0]            ddr_size,
  output logic [UI_WIDTH-1:0]   m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  len_err,
  output logic                  proto_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      MAX_BURST_W = 16'(MAX_BURST);

  localparam logic [2:0] CMD_READ = 3'd1;
  localparam logic [2:0] CMD_IDLE = 3'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Control registers
  logic [1:0]            r_state;
  logic                  r_start_1d;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_remaining;
  logic [15:0]           r_beat_cnt;
  logic [2:0]            r_cmd;
  logic                  r_cmd_valid;
  logic [ADDR_WIDTH-1:0] r_base_addr;
  logic [9:0]            r_size;
  logic                  r_done;
  logic                  r_len_err;
  logic                  r_proto_err;

  // FIFO: storage array plus a registered output stage. r_count covers both.
  logic [UI_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_mvalid;
  logic [UI_WIDTH-1:0] r_mdata;

  logic                  w_start_edge;
  logic [9:0]            w_chunk;
  logic [CNT_W-1:0]      w_free;
  logic                  w_space_ok;
  logic                  w_in_recv;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic [CNT_W-1:0]      w_mem_cnt;
  logic                  w_load;
  logic                  w_proto_evt;
  logic [15:0]           w_beats_at_fin;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [15:0]           w_rem_next;

  assign w_start_edge = rd_start & ~r_start_1d;
  assign w_chunk      = (r_remaining > MAX_BURST_W) ? MAX_BURST_W[9:0] : r_remaining[9:0];
  assign w_free       = DEPTH_C - r_count;
  assign w_space_ok   = 16'(w_free) >= 16'(w_chunk);

  assign w_in_recv  = (r_state == ST_RECV);
  assign w_push_req = ddr_rd_data_valid & w_in_recv;
  assign w_pop      = r_mvalid & m_ready;
  assign w_full     = (r_count == DEPTH_C);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_mem_cnt  = r_count - CNT_W'(r_mvalid);
  // Refill the output stage from the array when it is empty or being consumed.
  assign w_load     = (~r_mvalid | w_pop) & (w_mem_cnt != '0);

  assign w_proto_evt = (ddr_rd_data_valid & ~w_in_recv) | (w_push_req & ~w_push);

  // A beat arriving together with the finish pulse still counts towards the chunk.
  assign w_beats_at_fin = r_beat_cnt + 16'(ddr_rd_data_valid);
  assign w_addr_inc     = ADDR_WIDTH'(r_size) * ADDR_WIDTH'(ADDR_STEP);
  assign w_rem_next     = r_remaining - 16'(r_size);

  always_ff @(posedge ui_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ddr_rd_data;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (!ui_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_load) begin
        r_mdata  <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_mvalid <= 1'b1;
      end else if (w_pop) begin
        r_mvalid <= 1'b0;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ui_clk) begin
    if (!ui_rst_n) begin
      r_state     <= ST_IDLE;
      r_start_1d  <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_beat_cnt  <= '0;
      r_cmd       <= CMD_IDLE;
      r_cmd_valid <= 1'b0;
      r_base_addr <= '0;
      r_size      <= '0;
      r_done      <= 1'b0;
      r_len_err   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_start_1d  <= rd_start;
      // Command strobe is a single-cycle pulse.
      r_cmd_valid <= 1'b0;
      r_cmd       <= CMD_IDLE;

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (r_state == ST_DONE && r_count == '0) begin
            r_done <= 1'b1;
          end
          if (w_start_edge) begin
            r_addr      <= rd_base_addr;
            r_remaining <= rd_total;
            r_beat_cnt  <= '0;
            r_done      <= 1'b0;
            r_len_err   <= 1'b0;
            r_proto_err <= 1'b0;
            r_state     <= (rd_total == 16'd0) ? ST_DONE : ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (w_space_ok && ddr_rdy) begin
            r_cmd       <= CMD_READ;
            r_cmd_valid <= 1'b1;
            r_base_addr <= r_addr;
            r_size      <= w_chunk;
            r_state     <= ST_RECV;
          end
        end

        ST_RECV: begin
          if (ddr_rd_finish) begin
            if (w_beats_at_fin != 16'(r_size)) begin
              r_len_err <= 1'b1;
            end
            r_addr      <= r_addr + w_addr_inc;
            r_remaining <= w_rem_next;
            r_beat_cnt  <= '0;
            r_state     <= (w_rem_next == 16'd0) ? ST_DONE : ST_WAIT;
          end else if (ddr_rd_data_valid) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase

      // Error events win over the clear performed by an accepted start.
      if (w_proto_evt) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign ddr_cmd       = r_cmd;
  assign ddr_cmd_valid = r_cmd_valid;
  assign ddr_base_addr = r_base_addr;
  assign ddr_size      = r_size;
  assign m_data        = r_mdata;
  assign m_valid       = r_mvalid;
  assign rd_busy       = (r_state == ST_WAIT) | (r_state == ST_RECV);
  assign rd_done       = r_done;
  assign len_err       = r_len_err;
  assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_ddr3_rd_stream.sv
// Testbench for ddr3_rd_stream: a DDR read responder model, a transfer-level reference model
// that predicts commands and beats, and a negedge monitor that scoreboards both streams.
module tb_ddr3_rd_stream;

  localparam int UIW = 512;
  localparam int AW  = 29;

  logic           ui_clk = 1'b0;
  logic           ui_rst_n = 1'b0;
  logic           rd_start = 1'b0;
  logic [AW-1:0]  rd_base_addr = '0;
  logic [15:0]    rd_total = '0;
  logic           ddr_rdy = 1'b1;
  logic [UIW-1:0] ddr_rd_data = '0;
  logic           ddr_rd_data_valid = 1'b0;
  logic           ddr_rd_finish = 1'b0;
  logic [2:0]     ddr_cmd;
  logic           ddr_cmd_valid;
  logic [AW-1:0]  ddr_base_addr;
  logic [9:0]     ddr_size;
  logic [UIW-1:0] m_data;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic           rd_busy;
  logic           rd_done;
  logic           len_err;
  logic           proto_err;

  ddr3_rd_stream dut (
    .ui_clk            (ui_clk),
    .ui_rst_n          (ui_rst_n),
    .rd_start          (rd_start),
    .rd_base_addr      (rd_base_addr),
    .rd_total          (rd_total),
    .ddr_rdy           (ddr_rdy),
    .ddr_rd_data       (ddr_rd_data),
    .ddr_rd_data_valid (ddr_rd_data_valid),
    .ddr_rd_finish     (ddr_rd_finish),
    .ddr_cmd           (ddr_cmd),
    .ddr_cmd_valid     (ddr_cmd_valid),
    .ddr_base_addr     (ddr_base_addr),
    .ddr_size          (ddr_size),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .rd_busy           (rd_busy),
    .rd_done           (rd_done),
    .len_err           (len_err),
    .proto_err         (proto_err)
  );

  always #5 ui_clk = ~ui_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+9:0]  cmd_q [$];
  logic [UIW-1:0] exp_q [$];

  int          occ = 0;        // beats held in the DUT FIFO, tracked by the bench
  bit          ignore_push = 1'b0;
  int          cmd_cnt = 0;
  int          third_occ = -1;
  bit          rand_ready = 1'b0;
  bit          beat_gaps = 1'b0;
  bit          short_next = 1'b0;
  bit          resp_busy = 1'b0;
  logic [31:0] salt = 32'h0;

  logic [AW+9:0]  mon_cmd;
  logic [UIW-1:0] mon_beat;
  logic [AW-1:0]  resp_addr;
  int             resp_n;
  bit             resp_together;

  function automatic logic [UIW-1:0] beat_data(input logic [AW-1:0] a);
    logic [UIW-1:0] d;
    for (int i = 0; i < UIW / 32; i++) d[i*32 +: 32] = {3'b000, a} ^ (salt + 32'(i));
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, between active edges.
  always @(negedge ui_clk) begin
    if (ui_rst_n && ddr_cmd_valid) begin
      cmd_cnt++;
      if (cmd_cnt == 3) third_occ = occ;
      if (cmd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_cmd: got addr 0x%0h size %0d, required no command",
                 ddr_base_addr, ddr_size);
      end else begin
        mon_cmd = cmd_q.pop_front();
        chk("cmd_code", 64'(ddr_cmd), 64'd1);
        chk("cmd_addr", 64'(ddr_base_addr), 64'(mon_cmd[AW+9:10]));
        chk("cmd_size", 64'(ddr_size), 64'(mon_cmd[9:0]));
      end
    end
    if (m_valid && m_ready) begin
      occ--;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got 0x%0h, required no beat", m_data[63:0]);
      end else begin
        mon_beat = exp_q.pop_front();
        n_checks++;
        if (m_data !== mon_beat) begin
          n_fail++;
          $display("FAIL beat_data: got 0x%0h, required 0x%0h", m_data, mon_beat);
        end
      end
    end
    if (ddr_rd_data_valid && !ignore_push) occ++;
  end

  // DDR read responder: answers each READ command with beats addressed from ddr_base_addr.
  initial forever begin
    @(negedge ui_clk);
    if (ui_rst_n && ddr_cmd_valid && ddr_cmd == 3'd1) begin
      resp_busy     = 1'b1;
      resp_addr     = ddr_base_addr;
      resp_n        = short_next ? 100 : int'(ddr_size);
      short_next    = 1'b0;
      resp_together = 1'($urandom_range(0, 1));
      for (int j = 0; j < resp_n; j++) begin
        @(posedge ui_clk); #1;
        ddr_rd_data_valid = 1'b0;
        if (beat_gaps) begin
          while ($urandom_range(0, 3) == 0) begin
            @(posedge ui_clk); #1;
          end
        end
        ddr_rd_data_valid = 1'b1;
        ddr_rd_data       = beat_data(resp_addr + AW'(j * 8));
        if (resp_together && j == resp_n - 1) ddr_rd_finish = 1'b1;
      end
      @(posedge ui_clk); #1;
      ddr_rd_data_valid = 1'b0;
      ddr_rd_finish     = 1'b0;
      if (!resp_together) begin
        ddr_rd_finish = 1'b1;
        @(posedge ui_clk); #1;
        ddr_rd_finish = 1'b0;
      end
      resp_busy = 1'b0;
    end
  end

  initial forever begin
    @(posedge ui_clk); #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ui_clk); #1;
    end
  endtask

  // Reference model: chunking, addresses and returned beats derived from the transfer
  // parameters alone, then the start pulse.
  task automatic start_xfer(input logic [AW-1:0] base, input int total, input bit short_first);
    logic [AW-1:0] a;
    int            rem;
    int            c;
    int            nret;
    bit            first;
    a          = base;
    rem        = total;
    first      = 1'b1;
    salt       = $urandom;
    short_next = short_first;
    while (rem > 0) begin
      c = (rem > 128) ? 128 : rem;
      cmd_q.push_back({a, 10'(c)});
      nret = (first && short_first) ? 100 : c;
      for (int j = 0; j < nret; j++) exp_q.push_back(beat_data(a + AW'(j * 8)));
      a     = a + AW'(c * 8);
      rem  -= c;
      first = 1'b0;
    end
    rd_base_addr = base;
    rd_total     = 16'(total);
    rd_start     = 1'b1;
    step(1);
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (rd_done !== 1'b1 && k < 5000) begin
      step(1);
      k++;
    end
    chk({name, "_rd_done"}, 64'(rd_done), 64'd1);
  endtask

  task automatic end_checks(input string name, input logic exp_len_err);
    chk({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_cmds_left"}, 64'(cmd_q.size()), 64'd0);
    chk({name, "_len_err"}, 64'(len_err), 64'(exp_len_err));
    chk({name, "_proto_err"}, 64'(proto_err), 64'd0);
    chk({name, "_rd_busy"}, 64'(rd_busy), 64'd0);
  endtask

  task automatic reset_checks(input string p);
    chk({p, "_ddr_cmd"}, 64'(ddr_cmd), 64'd2);
    chk({p, "_cmd_valid"}, 64'(ddr_cmd_valid), 64'd0);
    chk({p, "_base_addr"}, 64'(ddr_base_addr), 64'd0);
    chk({p, "_size"}, 64'(ddr_size), 64'd0);
    chk({p, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({p, "_rd_busy"}, 64'(rd_busy), 64'd0);
    chk({p, "_rd_done"}, 64'(rd_done), 64'd0);
    chk({p, "_len_err"}, 64'(len_err), 64'd0);
    chk({p, "_proto_err"}, 64'(proto_err), 64'd0);
  endtask

  initial begin
    int k;
    int mv_seen;
    logic [AW-1:0] base;

    step(3);
    reset_checks("reset");
    ui_rst_n = 1'b1;
    step(2);

    // 1: 300 beats, consumer always ready
    m_ready = 1'b1;
    cmd_cnt = 0;
    start_xfer(29'h100, 300, 1'b0);
    wait_done("t1");
    end_checks("t1", 1'b0);
    chk("t1_cmd_count", 64'(cmd_cnt), 64'd3);

    // 2: backpressure holds off the third command
    m_ready   = 1'b0;
    cmd_cnt   = 0;
    third_occ = -1;
    start_xfer(AW'($urandom) & ~AW'(7), 300, 1'b0);
    k = 0;
    while (occ != 256 && k < 3000) begin
      step(1);
      k++;
    end
    chk("t2_buffered", 64'(occ), 64'd256);
    step(50);
    chk("t2_no_third_cmd", 64'(cmd_cnt), 64'd2);
    m_ready = 1'b1;
    wait_done("t2");
    chk("t2_third_occ_le212", 64'(third_occ <= 212), 64'd1);
    chk("t2_third_occ_ge200", 64'(third_occ >= 200), 64'd1);
    end_checks("t2", 1'b0);

    // 3: zero-length transfer
    cmd_cnt = 0;
    start_xfer(AW'($urandom), 0, 1'b0);
    step(1);
    chk("t3_rd_done", 64'(rd_done), 64'd1);
    chk("t3_no_cmd", 64'(cmd_cnt), 64'd0);
    chk("t3_rd_busy", 64'(rd_busy), 64'd0);

    // 4: controller not ready, then a start pulse while busy
    cmd_cnt = 0;
    ddr_rdy = 1'b0;
    start_xfer(AW'($urandom), 200, 1'b0);
    step(19);
    chk("t4_no_cmd_while_not_rdy", 64'(cmd_cnt), 64'd0);
    chk("t4_rd_busy", 64'(rd_busy), 64'd1);
    ddr_rdy = 1'b1;
    @(posedge ui_clk);
    @(negedge ui_clk);
    chk("t4_cmd_after_rdy", 64'(ddr_cmd_valid), 64'd1);
    @(posedge ui_clk); #1;
    step(10);
    rd_start = 1'b1;
    step(1);
    rd_start = 1'b0;
    wait_done("t4");
    chk("t4_cmd_count", 64'(cmd_cnt), 64'd2);
    end_checks("t4", 1'b0);

    // 5: short first chunk
    cmd_cnt = 0;
    start_xfer(AW'($urandom), 200, 1'b1);
    wait_done("t5");
    chk("t5_cmd_count", 64'(cmd_cnt), 64'd2);
    end_checks("t5", 1'b1);

    // 6: reset mid-transfer with 40 beats buffered
    m_ready = 1'b0;
    start_xfer(AW'($urandom), 300, 1'b0);
    k = 0;
    while (occ != 40 && k < 1000) begin
      step(1);
      k++;
    end
    chk("t6_buffered", 64'(occ), 64'd40);
    ignore_push = 1'b1;
    ui_rst_n    = 1'b0;
    step(1);
    ui_rst_n = 1'b1;
    reset_checks("t6_reset");
    occ = 0;
    cmd_q.delete();
    exp_q.delete();
    mv_seen = 0;
    k = 0;
    while (resp_busy && k < 500) begin
      if (m_valid) mv_seen++;
      step(1);
      k++;
    end
    chk("t6_responder_idle", 64'(resp_busy), 64'd0);
    step(2);
    chk("t6_proto_err", 64'(proto_err), 64'd1);
    chk("t6_no_output", 64'(mv_seen), 64'd0);
    chk("t6_m_valid", 64'(m_valid), 64'd0);
    ignore_push = 1'b0;

    // 7: random transfers with random consumer stalls and beat gaps
    rand_ready = 1'b1;
    beat_gaps  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      base = (i == 0) ? 29'h1FFF_FE00 : AW'($urandom);
      start_xfer(base, (i == 0) ? 150 : int'($urandom_range(1, 400)), 1'b0);
      wait_done("t7");
      end_checks("t7", 1'b0);
    end
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_rd_stream.md
Name: ddr3_rd_stream

Overview:
- Read-side counterpart of the DDR3 init writer on the same DDR user-command interface (`ddr_cmd`/`ddr_cmd_valid`/`ddr_base_addr`/`ddr_size`).
- On a start trigger it reads `rd_total` UI-width beats from DDR, starting at `rd_base_addr`.
- Reads are issued as chunks of at most `MAX_BURST` beats. A command is issued only when the internal FIFO has room for the whole chunk, because DDR read data has no backpressure.
- Beats are delivered in order to a valid/ready consumer (accelerator weight/feature loaders).

Parameters:
- DDR_WIDTH, 64, DDR data width in bits
- UI_WIDTH, DDR_WIDTH*8, width of one read beat
- ADDR_WIDTH, 29, DDR address width
- ADDR_STEP, 8, address increment per beat
- FIFO_DEPTH, 256, output FIFO entries; power of 2
- MAX_BURST, 128, maximum beats per read command; must satisfy 1 ≤ MAX_BURST ≤ min(1023, FIFO_DEPTH)

Ports:
- ui_clk  in  1  clock
- ui_rst_n  in  1  synchronous active-low reset
- rd_start  in  1  start trigger, rising-edge detected
- rd_base_addr  in  ADDR_WIDTH  start address, latched on start
- rd_total  in  16  beats to read, latched on start
- ddr_rdy  in  1  controller accepts a command
- ddr_rd_data  in  UI_WIDTH  read beat
- ddr_rd_data_valid  in  1  read beat valid; no backpressure
- ddr_rd_finish  in  1  one-cycle pulse, current read command complete
- ddr_cmd  out  3  0=WRITE, 1=READ, 2=IDLE
- ddr_cmd_valid  out  1  command strobe
- ddr_base_addr  out  ADDR_WIDTH  chunk start address
- ddr_size  out  10  chunk length in beats
- m_data  out  UI_WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- rd_busy  out  1  transfer in progress
- rd_done  out  1  transfer complete and FIFO drained
- len_err  out  1  sticky: beat count at finish ≠ chunk size
- proto_err  out  1  sticky: unexpected beat, or push while full

Behaviour:
- Reset (ui_rst_n=0 at a clock edge):
  - Output values: ddr_cmd=2, ddr_cmd_valid=0, ddr_base_addr=0, ddr_size=0, m_valid=0, rd_busy=0, rd_done=0, len_err=0, proto_err=0.
  - FIFO is flushed, state=IDLE, start edge register cleared.
  - A reset mid-transfer abandons the transfer; later ddr_rd_data_valid beats are proto_err.
- Start: start_edge = rd_start & ~rd_start_1d. Start edges while rd_busy=1 are ignored.
- IDLE: on start_edge, latch cur_addr=rd_base_addr and remaining=rd_total, clear rd_done/len_err/proto_err, and set rd_busy=1.
  - rd_total=0 → DONE.
  - Otherwise → WAIT_SPACE.
- WAIT_SPACE:
  - chunk = min(remaining, MAX_BURST).
  - free = FIFO_DEPTH − fifo_count, evaluated in the same cycle.
  - When free ≥ chunk and ddr_rdy=1, register ddr_cmd=1, ddr_cmd_valid=1, ddr_base_addr=cur_addr, ddr_size=chunk → RECV.
  - ddr_cmd_valid is high for exactly one cycle. It drops on the next cycle and ddr_cmd returns to 2.
- RECV:
  - Each ddr_rd_data_valid pushes ddr_rd_data into the FIFO and increments beat_cnt.
  - On ddr_rd_finish: set len_err if beat_cnt (including a beat arriving in the same cycle) ≠ chunk. Then cur_addr += chunk*ADDR_STEP (mod 2^ADDR_WIDTH), remaining −= chunk, beat_cnt=0.
  - remaining=0 → DONE; otherwise → WAIT_SPACE.
- DONE: rd_busy=0. rd_done=1 once the FIFO is empty, and holds until the next start_edge or reset. Next state is IDLE-equivalent: a new start_edge is accepted.
- ddr_rd_data_valid outside RECV: beat is dropped and proto_err is set.
- FIFO:
  - First-word-fall-through: a beat pushed at edge N gives m_valid=1 with that data after edge N+1.
  - A pop occurs when m_valid & m_ready.
  - Simultaneous push and pop is allowed at any occupancy, and count is unchanged.
  - Push while full and not popping: beat is dropped and proto_err is set. This is unreachable when the controller obeys ddr_size.
  - Ordering is strict by issue order.
- Never more than one read command outstanding.

Test Plan:
1. Read 300 beats, consumer always ready.
   - Stimulus: base=0x100, rd_total=300, m_ready=1, model returns ddr_size beats then a finish pulse.
   - Required: commands (0x100,128), (0x500,128), (0x900,44); 300 beats out in order; rd_done=1; no errors.
2. Backpressure holds off the third command.
   - Stimulus: m_ready=0, rd_total=300.
   - Required: after 256 beats buffered, no third ddr_cmd_valid. After raising m_ready, the third command issues only once fifo_count ≤ 212.
3. Zero-length transfer.
   - Stimulus: rd_total=0.
   - Required: no ddr_cmd_valid; rd_done=1 within 2 cycles of the start edge.
4. Controller not ready, and start while busy.
   - Stimulus: hold ddr_rdy=0 for 20 cycles in WAIT_SPACE; pulse rd_start during RECV.
   - Required: no command while ddr_rdy=0; the command issues the cycle after ddr_rdy rises; the mid-transfer start pulse is ignored.
5. Short chunk.
   - Stimulus: model asserts finish after only 100 of 128 beats.
   - Required: len_err=1 (sticky); the transfer continues to the next chunk at base+128*8.
6. Reset mid-transfer.
   - Stimulus: ui_rst_n=0 for 1 cycle during RECV with 40 beats buffered.
   - Required: next cycle all outputs at reset values and m_valid=0. Beats arriving afterwards set proto_err and are not output.
